// File: rtl/ram_bist_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : ram_bist_ctrl_if                                       |
// | Purpose  : Port bundle between the BIST controller and the 8x8    |
// |            single-port RAM (write data, address, write enable     |
// |            and read data).                                        |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
interface ram_bist_ctrl_if;
  logic [7:0] ram_data;
  logic [2:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_q;

  // Controller side drives the RAM inputs and observes q
  modport master (
    output ram_data,
    output ram_addr,
    output ram_we,
    input  ram_q
  );

  // RAM side
  modport slave (
    input  ram_data,
    input  ram_addr,
    input  ram_we,
    output ram_q
  );
endinterface
`default_nettype wire

// File: rtl/ram_bist_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : ram_bist_ctrl                                          |
// | Purpose  : Two-pass write / read-compare self test of an 8x8      |
// |            single-port RAM with pass/fail and first-error report. |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module ram_bist_ctrl #(
  parameter logic [7:0] SEED   = 8'h01,
  parameter int         RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  ram_bist_ctrl_if.master ram,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic [3:0]      err_count,
  output logic [2:0]      first_fail_addr,
  output logic            first_fail_pass
);

  // Phase counter covers 8 issue cycles plus the read drain cycles
  localparam int                CNT_W       = $clog2(8 + RD_LAT);
  localparam logic [CNT_W-1:0]  CNT_WR_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0]  CNT_RD_LAST = CNT_W'(7 + RD_LAT);
  localparam logic [CNT_W-1:0]  CNT_ISSUE   = CNT_W'(8);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR0  = 3'd1,
    S_RD0  = 3'd2,
    S_WR1  = 3'd3,
    S_RD1  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  logic       we_c;
  logic [2:0] addr_c;
  logic [7:0] data_c;
  logic       issue;
  logic       pass_idx;
  logic [7:0] base;
  logic [7:0] pattern;

  // Expected-value pipeline, aligned with the RAM read latency
  logic       pipe_valid [RD_LAT];
  logic [7:0] pipe_exp   [RD_LAT];
  logic [2:0] pipe_addr  [RD_LAT];
  logic       pipe_pass  [RD_LAT];

  logic       mismatch;
  logic       final_cmp;
  logic [3:0] err_inc;
  logic [3:0] err_final;

  // Pass 1 uses the bitwise complement of the pass-0 pattern
  assign pass_idx = (state == S_WR1) || (state == S_RD1);
  assign base     = SEED + {5'b0, cnt[2:0]};
  assign pattern  = pass_idx ? ~base : base;

  assign ram.ram_we   = we_c;
  assign ram.ram_addr = addr_c;
  assign ram.ram_data = data_c;

  assign mismatch  = pipe_valid[RD_LAT-1] && (ram.ram_q != pipe_exp[RD_LAT-1]);
  assign final_cmp = (state == S_RD1) && (cnt == CNT_RD_LAST);
  assign err_inc   = (err_count == 4'hF) ? err_count : err_count + 4'd1;
  assign err_final = mismatch ? err_inc : err_count;

  // State and phase-counter register; reset aborts a test immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state sequencing and RAM port drive for each phase
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    busy       = 1'b0;
    done       = 1'b0;
    we_c       = 1'b0;
    addr_c     = 3'd0;
    data_c     = 8'd0;
    issue      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_WR0;
          cnt_next   = '0;
        end
      end
      S_WR0, S_WR1: begin
        busy   = 1'b1;
        we_c   = 1'b1;
        addr_c = cnt[2:0];
        data_c = pattern;
        if (cnt == CNT_WR_LAST) begin
          state_next = (state == S_WR0) ? S_RD0 : S_RD1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_RD0, S_RD1: begin
        busy   = 1'b1;
        issue  = (cnt < CNT_ISSUE);
        // Address parks on 7 while the last reads drain
        addr_c = issue ? cnt[2:0] : 3'd7;
        if (cnt == CNT_RD_LAST) begin
          state_next = (state == S_RD0) ? S_WR1 : S_DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Delay expected data, address and pass index by the read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_exp[i]   <= 8'd0;
        pipe_addr[i]  <= 3'd0;
        pipe_pass[i]  <= 1'b0;
      end
    end else begin
      pipe_valid[0] <= issue;
      pipe_exp[0]   <= pattern;
      pipe_addr[0]  <= cnt[2:0];
      pipe_pass[0]  <= pass_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_exp[i]   <= pipe_exp[i-1];
        pipe_addr[i]  <= pipe_addr[i-1];
        pipe_pass[i]  <= pipe_pass[i-1];
      end
    end
  end

  // Error accounting and final verdict; the verdict includes the last drain compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass            <= 1'b0;
      fail            <= 1'b0;
      err_count       <= 4'd0;
      first_fail_addr <= 3'd0;
      first_fail_pass <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      pass            <= 1'b0;
      fail            <= 1'b0;
      err_count       <= 4'd0;
      first_fail_addr <= 3'd0;
      first_fail_pass <= 1'b0;
    end else begin
      if (mismatch) begin
        err_count <= err_inc;
        if (err_count == 4'd0) begin
          first_fail_addr <= pipe_addr[RD_LAT-1];
          first_fail_pass <= pipe_pass[RD_LAT-1];
        end
      end
      if (final_cmp) begin
        pass <= (err_final == 4'd0);
        fail <= (err_final != 4'd0);
      end
    end
  end

endmodule
`default_nettype wire
